dpot_spi_rx: RTL
================

Name: dpot_spi_rx

Overview:
- Receive-side counterpart of the digipot SPI writer: the slave end of the three-chip-select serial link (cs1/cs2/cs3, sdi, clk_out).
- Oversamples the link in the system clock domain and deserialises MSB-first frames.
- Reports each completed frame with its channel.
- Keeps a shadow wiper register per potentiometer, used as a bench/loopback checker and as a readback of the last value written to each pot.

Parameters:
- BITS, 8, frame length in bits (shift register and data width).
- WIPER_RST, 8'h80, reset value of every shadow wiper register.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- cs1  in  1  chip select pot 1, active-low, asynchronous to clk.
- cs2  in  1  chip select pot 2, active-low, asynchronous to clk.
- cs3  in  1  chip select pot 3, active-low, asynchronous to clk.
- sdi  in  1  serial data, MSB first, sampled on serial-clock rising edge.
- clk_in  in  1  serial clock from the writer's clk_out, idle low.
- dato_out  out  BITS  last valid frame data.
- canal  out  2  channel of last frame: 1=cs1, 2=cs2, 3=cs3, 0=none since reset.
- valid  out  1  one-cycle pulse when a correct frame completes.
- err  out  1  one-cycle pulse on frame error.
- wiper1  out  BITS  shadow value for pot 1.
- wiper2  out  BITS  shadow value for pot 2.
- wiper3  out  BITS  shadow value for pot 3.

Behaviour:
- Synchronisation
  - All five link inputs pass through 2-flop synchronisers.
  - Synchroniser reset values: cs = 1, clk_in = 0, sdi = 0.
  - Serial rising edge = synced clk_in 0->1 across consecutive clk cycles.
  - clk_in high and low times must each be at least 2 clk periods. Faster input is out of spec.
- Reset values (rst_n low at a clk edge)
  - dato_out = 0, canal = 0, valid = 0, err = 0, wiper1..3 = WIPER_RST.
  - FSM = IDLE, bit counter = 0, shift register = 0.
  - Reset mid-frame aborts the frame silently, with no valid or err pulse.
- IDLE
  - Exactly one synced cs low: latch its channel number, clear the counter and shift register, go to SHIFT.
  - Two or more cs low: pulse err, go to WAIT.
- SHIFT
  - On each serial rising edge: shreg <= {shreg[BITS-2:0], sdi_sync}; counter increments, saturating at 15.
  - Another cs goes low while the latched cs is low: pulse err, go to WAIT. No wiper update.
  - Latched cs returns high with counter == BITS: go to DONE.
  - Latched cs returns high with counter != BITS (short or long frame): pulse err, return to IDLE, outputs unchanged.
  - A serial edge in the same cycle as cs deassertion is ignored. cs takes priority.
- DONE (one cycle)
  - valid = 1, dato_out <= shreg, canal <= latched channel.
  - The matching wiperN <= shreg; the other wipers hold.
  - Next state IDLE.
- WAIT
  - Ignore clk_in and sdi until all synced cs are high, then go to IDLE.
- Latency: valid rises 4 clk cycles after the pin-level rising edge of cs (2 sync + 1 detect + 1 DONE).
- Back-to-back frames: a new cs assertion is accepted from IDLE on the cycle after DONE. The minimum cs-high gap is 3 clk.
- valid and err never assert in the same cycle.

Test Plan:
- Frame on cs1, 8 rising edges, data 0xAA -> one valid pulse; dato_out=0xAA, canal=1, wiper1=0xAA, wiper2=wiper3=0x80; valid 4 clk after cs1 rises.
- Frame on cs3 with 0x55, then on cs2 with 0x0F, 3-clk cs gap -> two valid pulses in order; wiper3=0x55, wiper2=0x0F, canal ends at 2.
- Frame on cs2 with only 5 edges, then one with 9 edges -> err pulse each time, no valid; wiper2 stays 0x80.
- cs1 low, then cs3 low mid-frame -> err once; no update until both high; the following clean cs3 frame with 0x3C is accepted.
- rst_n low for 1 clk after 4 bits of a cs1 frame -> all outputs at reset values, no pulses; the remaining edges while cs1 stays low are discarded (FSM resumes only after cs1 high then low again).
- cs1 and cs2 asserted in the same cycle from idle -> err pulse, then WAIT until both high.

Source files
------------

// File: rtl/dpot_spi_rx.sv
// dpot_spi_rx: oversampling SPI slave for three digipots with per-pot shadow wiper registers
module dpot_spi_rx #(
    parameter int              BITS      = 8,
    parameter logic [BITS-1:0] WIPER_RST = 8'h80
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cs1,
    input  logic            cs2,
    input  logic            cs3,
    input  logic            sdi,
    input  logic            clk_in,
    output logic [BITS-1:0] dato_out,
    output logic [1:0]      canal,
    output logic            valid,
    output logic            err,
    output logic [BITS-1:0] wiper1,
    output logic [BITS-1:0] wiper2,
    output logic [BITS-1:0] wiper3
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    logic [4:0]      s1_q, s2_q;
    logic            sclk_prev_q;
    logic [1:0]      state_q, state_d;
    logic [1:0]      ch_q, ch_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [BITS-1:0] sh_q, sh_d;
    logic [BITS-1:0] dato_q, w1_q, w2_q, w3_q;
    logic [1:0]      canal_q;
    logic            valid_q, err_q, err_d;
    logic            arm_q;
    logic [1:0]      settle_q;

    logic [2:0] cs_s, sel;
    logic       sdi_s, rise, lat_hi, other_low, one_low, any_low;
    logic [1:0] new_ch;

    assign cs_s      = s2_q[2:0];
    assign sdi_s     = s2_q[3];
    assign rise      = s2_q[4] & ~sclk_prev_q;
    assign sel       = {ch_q == 2'd3, ch_q == 2'd2, ch_q == 2'd1};
    assign lat_hi    = |(cs_s & sel);
    assign other_low = ~&(cs_s | sel);
    assign one_low   = (cs_s == 3'b110) || (cs_s == 3'b101) || (cs_s == 3'b011);
    assign any_low   = cs_s != 3'b111;
    assign new_ch    = !cs_s[0] ? 2'd1 : !cs_s[1] ? 2'd2 : 2'd3;

    assign dato_out = dato_q;
    assign canal    = canal_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign wiper1   = w1_q;
    assign wiper2   = w2_q;
    assign wiper3   = w3_q;

    // two-flop synchronisers for {clk_in, sdi, cs3, cs2, cs1} plus serial-clock edge history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q        <= 5'b00111;
            s2_q        <= 5'b00111;
            sclk_prev_q <= 1'b0;
        end else begin
            s1_q        <= {clk_in, sdi, cs3, cs2, cs1};
            s2_q        <= s1_q;
            sclk_prev_q <= s2_q[4];
        end
    end

    // frame FSM: cs changes outrank a coincident serial edge
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm_q && one_low) begin
                    state_d = SHIFT;
                    ch_d    = new_ch;
                    cnt_d   = 4'd0;
                    sh_d    = '0;
                end else if (arm_q && any_low) begin
                    err_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            SHIFT: begin
                if (lat_hi) begin
                    state_d = (cnt_q == 4'(BITS)) ? DONE : IDLE;
                    err_d   = cnt_q != 4'(BITS);
                end else if (other_low) begin
                    err_d   = 1'b1;
                    state_d = WAIT;
                end else if (rise) begin
                    sh_d  = {sh_q[BITS-2:0], sdi_s};
                    cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = any_low ? WAIT : IDLE;
        endcase
    end

    // state, outputs and shadow wipers; arm blocks a frame already in progress across reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= 4'd0;
            sh_q     <= '0;
            dato_q   <= '0;
            canal_q  <= 2'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            w1_q     <= WIPER_RST;
            w2_q     <= WIPER_RST;
            w3_q     <= WIPER_RST;
            arm_q    <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            valid_q  <= state_q == DONE;
            err_q    <= err_d;
            settle_q <= settle_q + {1'b0, settle_q != 2'd3};
            arm_q    <= arm_q | (settle_q == 2'd3 && !any_low);
            if (state_q == DONE) begin
                dato_q  <= sh_q;
                canal_q <= ch_q;
                if (ch_q == 2'd1) w1_q <= sh_q;
                if (ch_q == 2'd2) w2_q <= sh_q;
                if (ch_q == 2'd3) w3_q <= sh_q;
            end
        end
    end
endmodule
